// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressable data memory: access-size
// encodings, clear/ready state type and lane helpers.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } dmem_state_e;

  // Byte lanes touched by an access of the given size at the given offset.
  // Reserved size (11) behaves as a word.
  function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << addr_lo;
      SZ_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // True when the offset is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

  // Clears the offset bits below the access size.
  function automatic logic [1:0] align_down(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
    logic [1:0] lo;
    case (size)
      SZ_BYTE: lo = addr_lo;
      SZ_HALF: lo = {addr_lo[1], 1'b0};
      default: lo = 2'b00;
    endcase
    return lo;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load path: picks the addressed byte/halfword out of a 32-bit word and
// sign- or zero-extends it. Purely combinational.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection followed by extension to 32 bits.
  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      SZ_BYTE: data_o = unsigned_i ? {24'd0, byte_sel}
                                   : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: data_o = unsigned_i ? {16'd0, half_sel}
                                   : {{16{half_sel[15]}}, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressable little-endian data memory, DEPTH x 32-bit words.
// After reset a CLEAR sequence zeroes one word per cycle (Busy=1), then the
// memory serves combinational loads and clocked byte/half/word stores.
// Optional feature macro DMEM_MISALIGN_TRAP_EN: when defined, misaligned
// accesses are flagged on Misalign, stores are dropped and loads return 0;
// when undefined, accesses are silently aligned down and Misalign is 0.
module byte_data_memory
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              WE,
  input  logic              RE,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              Busy,
  output logic              Misalign
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  dmem_state_e      state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic [31:0]      mem_q [DEPTH];

  logic [IDX_W-1:0] word_idx;
  logic [1:0]       eff_lo;
  logic [3:0]       wmask;
  logic [31:0]      wdata_rep;
  logic [31:0]      load_data;
  logic             store_en;
  logic             unused_addr_hi;

  // Upper address bits alias onto the array (wrap modulo DEPTH*4 bytes).
  assign word_idx       = Address[IDX_W+1:2];
  assign unused_addr_hi = ^{1'b0, Address[ADDR_W-1:IDX_W+2]};
  assign Busy           = (state_q == ST_CLEAR);

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis_raw;
  assign mis_raw   = is_misaligned(Size, Address[1:0]);
  assign eff_lo    = Address[1:0];
  assign store_en  = !Busy && WE && !mis_raw;
  assign Misalign  = !Busy && (RE || WE) && mis_raw;
  assign ReadData  = (!Busy && RE && !mis_raw) ? load_data : 32'd0;
`else
  assign eff_lo    = align_down(Size, Address[1:0]);
  assign store_en  = !Busy && WE;
  assign Misalign  = 1'b0;
  assign ReadData  = (!Busy && RE) ? load_data : 32'd0;
`endif

  assign wmask = lane_mask(Size, eff_lo);

  // Replicate the right-justified store data into every lane so the mask
  // alone decides which bytes land.
  always_comb begin
    case (Size)
      SZ_BYTE: wdata_rep = {4{WriteData[7:0]}};
      SZ_HALF: wdata_rep = {2{WriteData[15:0]}};
      default: wdata_rep = WriteData;
    endcase
  end

  // Clear sequencing: step through every index once, then stay ready.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == ST_CLEAR) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == LAST_IDX) state_d = ST_READY;
    end
  end

  // Control state; reset restarts the clear from index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Storage: zeroed only by the clear walk, otherwise lane-merged stores.
  always_ff @(posedge clk) begin
    if (Busy) begin
      mem_q[clr_idx_q] <= 32'd0;
    end else if (store_en) begin
      for (int l = 0; l < 4; l++) begin
        if (wmask[l]) mem_q[word_idx][8*l +: 8] <= wdata_rep[8*l +: 8];
      end
    end
  end

  dmem_load_align u_load_align (
    .word_i     (mem_q[word_idx]),
    .addr_lo_i  (eff_lo),
    .size_i     (Size),
    .unsigned_i (Unsigned),
    .data_o     (load_data)
  );

endmodule

// File: tb/tb_byte_data_memory.sv
// Bench for byte_data_memory at DEPTH=16: clear timing, directed vector
// table, reset corner sequences and a randomized run against a byte-array
// reference model.
module tb_byte_data_memory;

  localparam int DEPTH = 16;
  localparam int NBYTES = DEPTH * 4;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        WE, RE, Unsigned;
  logic [1:0]  Size;
  logic [31:0] Address, WriteData;
  logic [31:0] ReadData;
  logic        Busy, Misalign;

  int tests = 0;
  int fails = 0;

  byte_data_memory #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .WE(WE), .RE(RE), .Size(Size),
    .Unsigned(Unsigned), .Address(Address), .WriteData(WriteData),
    .ReadData(ReadData), .Busy(Busy), .Misalign(Misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic        we, re;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wd, exp_rd;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] mbytes [NBYTES];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic re, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    WE = we; RE = re; Size = size; Unsigned = uns; Address = addr; WriteData = wd;
    #2;
  endtask

  function automatic vec_t mk(input string name, input logic we, input logic re,
                              input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] exp_rd, input logic exp_mis);
    vec_t v;
    v.name = name; v.we = we; v.re = re; v.size = size; v.uns = uns;
    v.addr = addr; v.wd = wd; v.exp_rd = exp_rd; v.exp_mis = exp_mis;
    return v;
  endfunction

  // Counts cycles with Busy high after rst_n release (bounded).
  task automatic count_busy(output int n);
    n = 0;
    while (Busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Reference model helpers, operating on a flat byte array.
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_mis(input logic [1:0] size, input logic [31:0] addr);
    return (addr % nbytes(size)) != 0;
  endfunction

  function automatic int model_base(input logic [1:0] size, input logic [31:0] addr);
    int n;
    logic [31:0] a;
    n = nbytes(size);
    a = TRAP ? addr : addr - (addr % n);
    return int'(a % NBYTES);
  endfunction

  function automatic logic [31:0] model_load(input logic re, input logic [1:0] size,
                                             input logic uns, input logic [31:0] addr);
    int n, b;
    logic [31:0] v;
    if (!re) return 32'd0;
    if (TRAP && model_mis(size, addr)) return 32'd0;
    n = nbytes(size);
    b = model_base(size, addr);
    v = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(mbytes[b + k]) << (8 * k));
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic model_store(input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wd);
    int n, b;
    if (TRAP && model_mis(size, addr)) return;
    n = nbytes(size);
    b = model_base(size, addr);
    for (int k = 0; k < n; k++) mbytes[b + k] = wd[8*k +: 8];
  endtask

  initial begin
    int n;
    WE = 0; RE = 0; Size = 2'b10; Unsigned = 0; Address = 0; WriteData = 0;

    // Reset state, with a misaligned load request pending.
    rst_n = 1'b0;
    RE = 1'b1; Size = 2'b10; Address = 32'h3;
    #12;
    check("reset_busy", {31'd0, Busy}, 32'd1);
    check("reset_rdata", ReadData, 32'd0);
    check("reset_mis", {31'd0, Misalign}, 32'd0);

    // Clear length; stores requested throughout must be ignored.
    @(negedge clk);
    WE = 1'b1; Size = 2'b10; Address = 32'h0; WriteData = 32'hFFFF_FFFF;
    rst_n = 1'b1;
    count_busy(n);
    check("clear_cycles", n, 32'd16);
    for (int w = 0; w < DEPTH; w++) begin
      drive(1'b0, 1'b1, 2'b10, 1'b0, 32'(w * 4), 32'd0);
      check($sformatf("post_clear_w%0d", w), ReadData, 32'd0);
    end

    // Directed vectors; expectations are hand-derived.
    vecs.push_back(mk("st_w10",    1, 0, 2'b10, 0, 32'h10, 32'h8899AABC, 32'h0, 0));
    vecs.push_back(mk("lb_10",     0, 1, 2'b00, 0, 32'h10, 32'h0, 32'hFFFFFFBC, 0));
    vecs.push_back(mk("lb_11",     0, 1, 2'b00, 0, 32'h11, 32'h0, 32'hFFFFFFAA, 0));
    vecs.push_back(mk("lb_12",     0, 1, 2'b00, 0, 32'h12, 32'h0, 32'hFFFFFF99, 0));
    vecs.push_back(mk("lb_13",     0, 1, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFF88, 0));
    vecs.push_back(mk("lbu_13",    0, 1, 2'b00, 1, 32'h13, 32'h0, 32'h00000088, 0));
    vecs.push_back(mk("lw_10",     0, 1, 2'b10, 0, 32'h10, 32'h0, 32'h8899AABC, 0));
    vecs.push_back(mk("st_w20",    1, 0, 2'b10, 0, 32'h20, 32'hFFFFFFFF, 32'h0, 0));
    vecs.push_back(mk("st_h22",    1, 0, 2'b01, 0, 32'h22, 32'hABCD1234, 32'h0, 0));
    vecs.push_back(mk("lw_20",     0, 1, 2'b10, 0, 32'h20, 32'h0, 32'h1234FFFF, 0));
    vecs.push_back(mk("lh_20",     0, 1, 2'b01, 0, 32'h20, 32'h0, 32'hFFFFFFFF, 0));
    vecs.push_back(mk("lhu_22",    0, 1, 2'b01, 1, 32'h22, 32'h0, 32'h00001234, 0));
    vecs.push_back(mk("lw_rsv_20", 0, 1, 2'b11, 0, 32'h20, 32'h0, 32'h1234FFFF, 0));
    vecs.push_back(mk("st_w05",    1, 0, 2'b10, 0, 32'h05, 32'hDEADBEEF, 32'h0, TRAP));
    vecs.push_back(mk("lw_04",     0, 1, 2'b10, 0, 32'h04, 32'h0,
                      TRAP ? 32'h0 : 32'hDEADBEEF, 0));
    vecs.push_back(mk("st_b40",    1, 0, 2'b00, 0, 32'h40, 32'h0000005A, 32'h0, 0));
    vecs.push_back(mk("lw_00",     0, 1, 2'b10, 0, 32'h00, 32'h0, 32'h0000005A, 0));
    vecs.push_back(mk("rw_same",   1, 1, 2'b10, 0, 32'h00, 32'h11223344, 32'h0000005A, 0));
    vecs.push_back(mk("lw_40",     0, 1, 2'b10, 0, 32'h40, 32'h0, 32'h11223344, 0));
    vecs.push_back(mk("re0",       0, 0, 2'b10, 0, 32'h40, 32'h0, 32'h0, 0));
    vecs.push_back(mk("lh_01",     0, 1, 2'b01, 0, 32'h01, 32'h0,
                      TRAP ? 32'h0 : 32'h00003344, TRAP));
    vecs.push_back(mk("lbu_hi_wrap", 0, 1, 2'b00, 1, 32'hFFFF_FFC3, 32'h0, 32'h00000011, 0));
    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].re, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wd);
      check({vecs[i].name, "_rd"}, ReadData, vecs[i].exp_rd);
      check({vecs[i].name, "_mis"}, {31'd0, Misalign}, {31'd0, vecs[i].exp_mis});
    end

    // Reset mid-operation: outputs drop immediately, full clear restarts.
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D);
    rst_n = 1'b0;
    #1;
    check("async_busy", {31'd0, Busy}, 32'd1);
    check("async_rdata", ReadData, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // Pulse reset again at clear cycle 7.
    repeat (7) @(posedge clk);
    #1;
    check("midclear_busy", {31'd0, Busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(n);
    check("restart_cycles", n, 32'd16);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'd0);
    check("reclear_w10", ReadData, 32'd0);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'd0);
    check("reclear_w20", ReadData, 32'd0);

    // Randomized traffic against the byte-array model (memory is zero now).
    for (int i = 0; i < NBYTES; i++) mbytes[i] = 8'd0;
    for (int i = 0; i < 400; i++) begin
      logic we, re, uns;
      logic [1:0] sz;
      logic [31:0] a, wd, exp_rd;
      logic exp_mis;
      we  = ($urandom_range(0, 1) == 1);
      re  = ($urandom_range(0, 3) != 0);
      uns = $urandom_range(0, 1);
      sz  = 2'($urandom_range(0, 3));
      a   = $urandom;
      wd  = $urandom;
      drive(we, re, sz, uns, a, wd);
      exp_rd  = model_load(re, sz, uns, a);
      exp_mis = TRAP && (re || we) && model_mis(sz, a);
      check($sformatf("rnd%0d_rd", i), ReadData, exp_rd);
      check($sformatf("rnd%0d_mis", i), {31'd0, Misalign}, {31'd0, exp_mis});
      if (we) model_store(sz, a, wd);
    end

    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
